// File: rtl/muldiv_seq_ctrl_pkg.sv
// Shared types for the iterative MULT/MULTU/DIV/DIVU sequencer: op and state encodings
// plus small op-decode helpers.
package muldiv_seq_ctrl_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic op_is_div(input op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_seq_ctrl_if.sv
// E-stage request / HI-LO result bundle between the pipeline (master) and the mul/div unit (slave).
// busy is combinational back to the hazard unit; done/hilo_we/hi/lo are registered.
interface muldiv_seq_ctrl_if
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);
  logic             start;
  op_t              op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic             busy;
  logic             done;
  logic             hilo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srca, srcb, flush,
    input  busy, done, hilo_we, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, flush,
    output busy, done, hilo_we, hi, lo
  );
endinterface

// File: rtl/muldiv_seq_ctrl_step.sv
// One iteration of the {acc, q} datapath: add-shift-right for multiply,
// restoring compare-subtract-shift-left for divide. Purely combinational.
module muldiv_seq_ctrl_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_opb,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_a;
  logic             w_ge;
  logic [WIDTH-1:0] w_div_acc;

  assign w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_opb} : '0);

  // Partial remainder can reach W+1 bits after the shift; the subtract result always fits W.
  assign w_rem_a   = {i_acc, i_q[WIDTH-1]};
  assign w_ge      = (w_rem_a >= {1'b0, i_opb});
  assign w_div_acc = w_ge ? WIDTH'(w_rem_a - {1'b0, i_opb}) : w_rem_a[WIDTH-1:0];

  assign o_acc = i_is_div ? w_div_acc : w_sum[WIDTH:1];
  assign o_q   = i_is_div ? {i_q[WIDTH-2:0], w_ge} : {w_sum[0], i_q[WIDTH-1:1]};
endmodule

// File: rtl/muldiv_seq_ctrl.sv
// Mul/div sequencer: accepts an op from E, runs WIDTH magnitude iterations, applies signs
// and commits HI/LO with a one-cycle hilo_we pulse. flush aborts RUN without touching HI/LO.
module muldiv_seq_ctrl
  import muldiv_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  muldiv_seq_ctrl_if.slave  io_mdu
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_done;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_sa;
  logic               w_sb;
  logic               w_accept;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_acc_nx;
  logic [WIDTH-1:0]   w_q_nx;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_hi_fin;
  logic [WIDTH-1:0]   w_lo_fin;

  assign w_sa     = op_is_signed(io_mdu.op) & io_mdu.srca[WIDTH-1];
  assign w_sb     = op_is_signed(io_mdu.op) & io_mdu.srcb[WIDTH-1];
  assign w_mag_a  = w_sa ? -io_mdu.srca : io_mdu.srca;
  assign w_mag_b  = w_sb ? -io_mdu.srcb : io_mdu.srcb;
  assign w_accept = (r_state == ST_IDLE) & io_mdu.start & ~io_mdu.flush;

  muldiv_seq_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div (r_is_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_opb    (r_opb),
    .o_acc    (w_acc_nx),
    .o_q      (w_q_nx)
  );

  // Final result is taken from the last step's combinational output so HI/LO land with done.
  assign w_prod   = {w_acc_nx, w_q_nx};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_hi_fin = r_is_div ? (r_neg_r ? -w_acc_nx : w_acc_nx) : w_prod_s[2*WIDTH-1:WIDTH];
  assign w_lo_fin = r_is_div ? (r_neg_q ? -w_q_nx : w_q_nx) : w_prod_s[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_RUN;
            r_cnt    <= CW'(WIDTH);
            r_is_div <= op_is_div(io_mdu.op);
            // A zero divisor must leave the quotient all ones, so never negate it.
            r_neg_q  <= (w_sa ^ w_sb) & (~op_is_div(io_mdu.op) | (|io_mdu.srcb));
            r_neg_r  <= w_sa;
            r_acc    <= '0;
            r_q      <= w_mag_a;
            r_opb    <= w_mag_b;
          end
        end
        ST_RUN: begin
          if (io_mdu.flush) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_hi    <= w_hi_fin;
              r_lo    <= w_lo_fin;
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_mdu.busy    = (r_state == ST_RUN) | w_accept;
  assign io_mdu.done    = r_done;
  assign io_mdu.hilo_we = r_done;
  assign io_mdu.hi      = r_hi;
  assign io_mdu.lo      = r_lo;
endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// Directed bench for muldiv_seq_ctrl: a vector table of single ops with exact timing,
// then hand sequences for flush, reset mid-op, ignored start and back-to-back ops.
module tb_muldiv_seq_ctrl;
  import muldiv_seq_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  muldiv_seq_ctrl_if #(.WIDTH(32)) mdu ();

  muldiv_seq_ctrl #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_mdu  (mdu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    op_t         op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to mid-cycle for sampling.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input op_t op, input logic [31:0] a, input logic [31:0] b);
    mdu.start = s;
    mdu.op    = op;
    mdu.srca  = a;
    mdu.srcb  = b;
  endtask

  // Entered at the start of cycle 0 with the unit idle; returns at the start of cycle 35.
  task automatic run_op(input string nm, input op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int bad_busy;
    int bad_done;
    bad_busy = 0;
    bad_done = 0;
    drive(1'b1, op, a, b);
    smp();
    chk({nm, " busy c0"}, 64'(mdu.busy), 64'd1);
    cyc();
    mdu.start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      smp();
      if (mdu.busy !== 1'b1) bad_busy++;
      if (mdu.done !== 1'b0 || mdu.hilo_we !== 1'b0) bad_done++;
      cyc();
    end
    smp();
    chk({nm, " busy c1-32"}, 64'(bad_busy), 64'd0);
    chk({nm, " early done"}, 64'(bad_done), 64'd0);
    chk({nm, " done c33"}, 64'(mdu.done), 64'd1);
    chk({nm, " hilo_we c33"}, 64'(mdu.hilo_we), 64'd1);
    chk({nm, " busy c33"}, 64'(mdu.busy), 64'd0);
    chk({nm, " hi"}, 64'(mdu.hi), 64'(ehi));
    chk({nm, " lo"}, 64'(mdu.lo), 64'(elo));
    cyc();
    smp();
    chk({nm, " done c34"}, 64'(mdu.done), 64'd0);
    chk({nm, " lo held c34"}, 64'(mdu.lo), 64'(elo));
    cyc();
  endtask

  initial begin
    int bad;
    n_chk  = 0;
    n_fail = 0;

    vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6]  = '{OP_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[9]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[10] = '{OP_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[11] = '{OP_MULT,  32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000000};

    rst_n     = 1'b0;
    mdu.flush = 1'b0;
    drive(1'b0, OP_MULT, 32'h0, 32'h0);
    cyc();
    cyc();
    smp();
    chk("reset busy", 64'(mdu.busy), 64'd0);
    chk("reset done", 64'(mdu.done), 64'd0);
    chk("reset hilo_we", 64'(mdu.hilo_we), 64'd0);
    chk("reset hi", 64'(mdu.hi), 64'd0);
    chk("reset lo", 64'(mdu.lo), 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 12; i++)
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Flush mid-run: prior HI/LO = 1 / FFFFFFFE from this MULTU.
    run_op("pre-flush", OP_MULTU, 32'hFFFFFFFF, 32'h2, 32'h1, 32'hFFFFFFFE);
    drive(1'b1, OP_DIVU, 32'd100, 32'd7);
    cyc();
    mdu.start = 1'b0;
    for (int k = 1; k <= 9; k++) cyc();
    mdu.flush = 1'b1;
    smp();
    chk("flush busy c10", 64'(mdu.busy), 64'd1);
    cyc();
    mdu.flush = 1'b0;
    chk("flush busy c11", 64'(mdu.busy), 64'd0);
    chk("flush no done c11", 64'(mdu.done), 64'd0);
    chk("flush hi kept", 64'(mdu.hi), 64'h1);
    chk("flush lo kept", 64'(mdu.lo), 64'hFFFFFFFE);
    #1;
    mdu.start = 1'b1;
    smp();
    chk("restart busy c11", 64'(mdu.busy), 64'd1);
    cyc();
    mdu.start = 1'b0;
    bad = 0;
    for (int k = 12; k <= 43; k++) begin
      smp();
      if (mdu.hilo_we !== 1'b0 || mdu.lo !== 32'hFFFFFFFE) bad++;
      cyc();
    end
    chk("restart quiet c12-43", 64'(bad), 64'd0);
    mdu.flush = 1'b1;
    smp();
    chk("restart done c44", 64'(mdu.hilo_we), 64'd1);
    chk("restart lo c44", 64'(mdu.lo), 64'd14);
    cyc();
    mdu.flush = 1'b0;
    smp();
    chk("flush in DONE hi", 64'(mdu.hi), 64'd2);
    chk("flush in DONE lo", 64'(mdu.lo), 64'd14);
    cyc();

    // start together with flush in IDLE is not accepted.
    drive(1'b1, OP_MULTU, 32'd3, 32'd3);
    mdu.flush = 1'b1;
    smp();
    chk("start+flush busy", 64'(mdu.busy), 64'd0);
    cyc();
    mdu.start = 1'b0;
    mdu.flush = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      smp();
      if (mdu.busy !== 1'b0 || mdu.hilo_we !== 1'b0) bad++;
      cyc();
    end
    chk("start+flush not accepted", 64'(bad), 64'd0);

    // start held during cycles 5..20 of a running MULT is ignored.
    drive(1'b1, OP_MULT, 32'hFFFFFFFF, 32'h2);
    cyc();
    mdu.start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 5) drive(1'b1, OP_MULTU, 32'd3, 32'd3);
      if (k == 21) mdu.start = 1'b0;
      cyc();
    end
    smp();
    chk("ignore-start done", 64'(mdu.done), 64'd1);
    chk("ignore-start hi", 64'(mdu.hi), 64'hFFFFFFFF);
    chk("ignore-start lo", 64'(mdu.lo), 64'hFFFFFFFE);
    cyc();
    cyc();

    // Synchronous reset at cycle 15 of a running op.
    drive(1'b1, OP_MULTU, 32'd3, 32'd3);
    cyc();
    mdu.start = 1'b0;
    for (int k = 1; k <= 14; k++) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    smp();
    chk("midrst busy", 64'(mdu.busy), 64'd0);
    chk("midrst done", 64'(mdu.done), 64'd0);
    chk("midrst hi", 64'(mdu.hi), 64'd0);
    chk("midrst lo", 64'(mdu.lo), 64'd0);
    cyc();
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      smp();
      if (mdu.busy !== 1'b0 || mdu.hilo_we !== 1'b0) bad++;
      cyc();
    end
    chk("midrst stays idle", 64'(bad), 64'd0);

    // Back-to-back with start held: MULTU then DIV 0x80000000 / -1.
    drive(1'b1, OP_MULTU, 32'hFFFFFFFF, 32'h2);
    cyc();
    drive(1'b1, OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    for (int k = 1; k <= 32; k++) cyc();
    smp();
    chk("b2b first done c33", 64'(mdu.done), 64'd1);
    chk("b2b first hi", 64'(mdu.hi), 64'h1);
    chk("b2b first lo", 64'(mdu.lo), 64'hFFFFFFFE);
    chk("b2b busy c33", 64'(mdu.busy), 64'd0);
    cyc();
    smp();
    chk("b2b busy c34", 64'(mdu.busy), 64'd1);
    cyc();
    mdu.start = 1'b0;
    bad = 0;
    for (int k = 35; k <= 66; k++) begin
      smp();
      if (mdu.busy !== 1'b1 || mdu.done !== 1'b0) bad++;
      cyc();
    end
    chk("b2b second run c35-66", 64'(bad), 64'd0);
    smp();
    chk("b2b second done c67", 64'(mdu.done), 64'd1);
    chk("b2b second hi", 64'(mdu.hi), 64'h0);
    chk("b2b second lo", 64'(mdu.lo), 64'h80000000);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
